mean_threshold_binarize: RTL and testbench

- Streaming binarization stage that sits directly upstream of the 3x3 morphology stages (dilation/erosion). It converts 8-bit grayscale raster pixels to pure 0 / all-ones values.
- The threshold is the integer mean of the previous frame's pixels. A serial divider computes it after each frame; the new value takes effect atomically at the next frame boundary.
- Supports an external threshold override and exports per-frame statistics.

---
 rtl/mean_threshold_binarize.sv | 180 ++++++++++++++++++
 tb/tb_mean_threshold_binarize.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mean_threshold_binarize.sv
// Binarizes a grayscale raster against the previous frame's mean.
// A serial restoring divider derives the mean; it is swapped in at frame start.
module mean_threshold_binarize #(
  parameter int IMAGE_WIDTH    = 320,
  parameter int IMAGE_HEIGHT   = 464,
  parameter int DATA_WIDTH     = 8,
  parameter int INIT_THRESHOLD = 128,
  parameter int INVERT         = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pixel_valid,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  thr_override_en,
  input  logic [DATA_WIDTH-1:0] thr_override,
  output logic                  pixel_out_valid,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic [DATA_WIDTH-1:0] thr_active,
  output logic                  mean_valid,
  output logic [DATA_WIDTH-1:0] mean_value
);

  localparam int N   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int SW  = DATA_WIDTH + $clog2(N);
  localparam int DVW = SW + 1;
  localparam int KW  = $clog2(DATA_WIDTH) + 1;

  localparam logic [DVW-1:0] DVS0 = DVW'(N) << (DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  localparam logic [DATA_WIDTH-1:0] THR0 = DATA_WIDTH'(INIT_THRESHOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [SW-1:0]         r_acc;
  logic [SW-1:0]         r_rem;
  logic [DVW-1:0]        r_dvs;
  logic [KW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_quot;
  logic [DATA_WIDTH-1:0] r_mean;
  logic                  r_mean_valid;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_thr;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out;

  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_first;
  logic                  w_last;
  logic [SW-1:0]         w_sum;
  logic                  w_swap;
  logic [DATA_WIDTH-1:0] w_thr_int;
  logic [DATA_WIDTH-1:0] w_thr;
  logic                  w_bin;
  logic                  w_step;

  assign w_col_last = (r_col == CW'(IMAGE_WIDTH - 1));
  assign w_row_last = (r_row == RW'(IMAGE_HEIGHT - 1));
  assign w_first    = pixel_valid && (r_col == '0) && (r_row == '0);
  assign w_last     = pixel_valid && w_col_last && w_row_last;
  assign w_sum      = r_acc + SW'(pixel_in);
  assign w_swap     = w_first && ((r_state == S_DONE) || r_pending);
  assign w_step     = ({1'b0, r_rem} >= r_dvs);

  // A mean finishing on the first pixel's cycle is taken straight from the divider
  always_comb begin
    w_thr_int = r_thr;
    if (w_first) begin
      if (r_state == S_DONE) begin
        w_thr_int = r_quot;
      end else if (r_pending) begin
        w_thr_int = r_mean;
      end
    end
  end

  assign w_thr = thr_override_en ? thr_override : w_thr_int;
  assign w_bin = (pixel_in >= w_thr) ^ (INVERT != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_last) w_state_nxt = S_DIV;
      end
      S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_DIV;
        end else if (r_cnt == KW'(DATA_WIDTH - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = w_last ? S_DIV : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_acc        <= '0;
      r_rem        <= '0;
      r_dvs        <= '0;
      r_cnt        <= '0;
      r_quot       <= '0;
      r_mean       <= '0;
      r_mean_valid <= 1'b0;
      r_pending    <= 1'b0;
      r_thr        <= THR0;
      r_out_valid  <= 1'b0;
      r_out        <= ONES;
    end else begin
      r_out_valid  <= pixel_valid;
      r_out        <= (pixel_valid && !w_bin) ? '0 : ONES;
      r_mean_valid <= 1'b0;

      if (pixel_valid) begin
        r_acc <= w_last ? '0 : w_sum;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      if (w_last) begin
        r_rem  <= w_sum;
        r_dvs  <= DVS0;
        r_cnt  <= '0;
        r_quot <= '0;
      end else if (r_state == S_DIV) begin
        if (w_step) r_rem <= r_rem - r_dvs[SW-1:0];
        r_quot <= {r_quot[DATA_WIDTH-2:0], w_step};
        r_dvs  <= r_dvs >> 1;
        r_cnt  <= r_cnt + 1'b1;
      end

      if (r_state == S_DONE) begin
        r_mean       <= r_quot;
        r_mean_valid <= 1'b1;
        r_pending    <= 1'b1;
      end

      if (w_swap) begin
        r_thr     <= w_thr_int;
        r_pending <= 1'b0;
      end
    end
  end

  assign pixel_out_valid = r_out_valid;
  assign pixel_out       = r_out;
  assign thr_active      = r_thr;
  assign mean_valid      = r_mean_valid;
  assign mean_value      = r_mean;

endmodule

// File: tb/tb_mean_threshold_binarize.sv
// Directed bench for mean_threshold_binarize on an 8x4 frame.
// Expected pixels and means are hand-computed constants.
module tb_mean_threshold_binarize;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_in = '0;
  logic       thr_override_en = 1'b0;
  logic [7:0] thr_override = '0;
  logic       pixel_out_valid;
  logic [7:0] pixel_out;
  logic [7:0] thr_active;
  logic       mean_valid;
  logic [7:0] mean_value;

  int n_run = 0;
  int n_fail = 0;
  int mv_cnt = 0;
  int c0;

  mean_threshold_binarize #(
    .IMAGE_WIDTH(8),
    .IMAGE_HEIGHT(4),
    .DATA_WIDTH(8),
    .INIT_THRESHOLD(128),
    .INVERT(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pixel_valid(pixel_valid),
    .pixel_in(pixel_in),
    .thr_override_en(thr_override_en),
    .thr_override(thr_override),
    .pixel_out_valid(pixel_out_valid),
    .pixel_out(pixel_out),
    .thr_active(thr_active),
    .mean_valid(mean_valid),
    .mean_value(mean_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mean_valid) mv_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic px(input logic [7:0] p, input int e, input string tag);
    pixel_valid = 1'b1;
    pixel_in    = p;
    @(posedge clk); #1;
    chk({tag, "_v"}, int'(pixel_out_valid), 1);
    chk(tag, int'(pixel_out), e);
    pixel_valid = 1'b0;
  endtask

  task automatic gap();
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    chk("gap_v", int'(pixel_out_valid), 0);
    chk("gap_out", int'(pixel_out), 255);
  endtask

  task automatic wait_mean(input int e, input string tag);
    int k;
    k = 0;
    pixel_valid = 1'b0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!mean_valid && k < 40);
    chk({tag, "_lat"}, k, 9);
    chk({tag, "_val"}, int'(mean_value), e);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, int'(mean_valid), 0);
  endtask

  task automatic frame_const(input logic [7:0] v, input int e,
                             input string tag);
    for (int i = 0; i < 32; i++) px(v, e, tag);
  endtask

  task automatic frame_split(input logic [7:0] a, input int ea,
                             input logic [7:0] b, input int eb,
                             input bit alt, input string tag);
    for (int i = 0; i < 32; i++) begin
      if (alt ? (i % 2 == 1) : (i >= 16)) px(b, eb, tag);
      else px(a, ea, tag);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ov"}, int'(pixel_out_valid), 0);
    chk({tag, "_out"}, int'(pixel_out), 255);
    chk({tag, "_thr"}, int'(thr_active), 128);
    chk({tag, "_mv"}, int'(mean_valid), 0);
    chk({tag, "_mval"}, int'(mean_value), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst0");
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame_const(8'd100, 0, "f1");
    chk("thr1", int'(thr_active), 128);
    wait_mean(100, "m1");
    frame_const(8'd100, 255, "f2");
    chk("thr2", int'(thr_active), 100);
    wait_mean(100, "m2");

    frame_split(8'd0, 0, 8'd255, 255, 1'b0, "f3");
    wait_mean(127, "m3");
    frame_split(8'd126, 0, 8'd127, 255, 1'b1, "f4");
    chk("thr4", int'(thr_active), 127);
    wait_mean(126, "m4");

    c0 = mv_cnt;
    frame_const(8'd200, 255, "f5");
    pixel_valid = 1'b0;
    @(posedge clk); #1;
    frame_const(8'd150, 255, "f6");
    chk("thr6", int'(thr_active), 126);
    chk("mean6", int'(mean_value), 200);
    wait_mean(150, "m6");
    chk("mvcnt56", mv_cnt - c0, 2);
    frame_split(8'd149, 0, 8'd150, 255, 1'b1, "f7");
    chk("thr7", int'(thr_active), 150);
    wait_mean(149, "m7");

    thr_override_en = 1'b1;
    thr_override    = 8'd50;
    for (int i = 0; i < 32; i++) begin
      px(8'(49 + i % 3), (i % 3 == 0) ? 0 : 255, "f8ovr");
    end
    thr_override_en = 1'b0;
    chk("thr8", int'(thr_active), 149);
    wait_mean(49, "m8");

    c0 = mv_cnt;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) px(8'd60, 255, "f9");
      else px(8'd40, 0, "f9");
      if (i < 31) begin
        gap();
        gap();
      end
    end
    wait_mean(50, "m9");
    chk("mvcnt9", mv_cnt - c0, 1);

    for (int i = 0; i < 10; i++) px(8'd200, 255, "f10");
    rst_n = 1'b0;
    #2;
    chk_reset("rstf");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    frame_const(8'd200, 255, "f11");
    repeat (3) @(posedge clk);
    #1;
    c0 = mv_cnt;
    rst_n = 1'b0;
    #2;
    chk_reset("rstd");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("nomv", mv_cnt - c0, 0);
    chk("nomval", int'(mean_value), 0);

    frame_split(8'd127, 0, 8'd128, 255, 1'b1, "f12");
    chk("thr12", int'(thr_active), 128);
    wait_mean(127, "m12");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
